// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR generator/checker pair: state encoding,
// default tap mask and the Galois next-state function with zero insertion.
package lfsr_pkg;

    // Widest LFSR the shared next-state function supports.
    localparam int LFSR_MAX_W = 64;

    // Default Galois tap mask for the 8-bit sequence.
    localparam logic [7:0] LFSR_POLY_DEFAULT = 8'h8C;

    // Checker state encoding.
    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } lfsr_state_e;

    // Galois step for an n-bit LFSR held in the low n bits of x.
    // The feedback bit is inverted when the low n-1 bits are all zero, so the
    // all-zero word is part of the cycle and the period is 2^n.
    // Bit 0 of poly is ignored: bit 0 always takes the feedback.
    function automatic logic [LFSR_MAX_W-1:0] lfsr_next(
        input logic [LFSR_MAX_W-1:0] x,
        input logic [LFSR_MAX_W-1:0] poly,
        input int                    n
    );
        logic                  low_zero;
        logic                  fb;
        logic [LFSR_MAX_W-1:0] nxt;
        low_zero = 1'b1;
        for (int i = 0; i < LFSR_MAX_W; i++) begin
            if ((i < n - 1) && x[i]) begin
                low_zero = 1'b0;
            end
        end
        fb     = x[n-1] ^ low_zero;
        nxt    = '0;
        nxt[0] = fb;
        for (int i = 1; i < LFSR_MAX_W; i++) begin
            if (i < n) begin
                nxt[i] = x[i-1] ^ (poly[i] & fb);
            end
        end
        return nxt;
    endfunction

endpackage

// File: rtl/lfsr_checker_param_err_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module lfsr_checker_param_err_counter #(
    parameter int NB_CNT = 16
) (
    input  logic              clk,
    input  logic              i_reset,
    input  logic              i_clr,
    input  logic              i_inc,
    output logic [NB_CNT-1:0] o_cnt
);

    logic [NB_CNT-1:0] cnt_reg;

    // Count up on increment, hold at all-ones, clear on request.
    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            cnt_reg <= '0;
        end else if (i_clr) begin
            cnt_reg <= '0;
        end else if (i_inc && (cnt_reg != {NB_CNT{1'b1}})) begin
            cnt_reg <= cnt_reg + NB_CNT'(1);
        end
    end

    assign o_cnt = cnt_reg;

endmodule

// File: rtl/lfsr_checker_param.sv
// PRBS/LFSR sequence checker: seeds a local reference from the received
// stream, qualifies it with LOCK_THR consecutive matches, then free-runs the
// reference and counts mismatches until UNLOCK_THR in a row drop lock.
module lfsr_checker_param
    import lfsr_pkg::*;
#(
    parameter int                 NB_LFSR    = 8,
    parameter logic [NB_LFSR-1:0] POLY       = 8'h8C,
    parameter int                 LOCK_THR   = 5,
    parameter int                 UNLOCK_THR = 3,
    parameter int                 NB_ERR_CNT = 16
) (
    input  logic                  clk,
    input  logic                  i_reset,
    input  logic                  i_valid,
    input  logic [NB_LFSR-1:0]    i_data,
    input  logic                  i_resync,
    input  logic                  i_clr_err,
    output logic [NB_LFSR-1:0]    o_expected,
    output logic                  o_lock,
    output logic                  o_match,
    output logic [NB_ERR_CNT-1:0] o_err_cnt
);

    // Counters are sized to hold their threshold value and never pass it.
    localparam int NB_GOOD = $clog2(LOCK_THR + 1);
    localparam int NB_BAD  = $clog2(UNLOCK_THR + 1);

    // Counter values at which the next event reaches the threshold.
    localparam logic [NB_GOOD-1:0] GOOD_LAST = NB_GOOD'(LOCK_THR - 1);
    localparam logic [NB_BAD-1:0]  BAD_LAST  = NB_BAD'(UNLOCK_THR - 1);

    lfsr_state_e         state_reg, state_next;
    logic [NB_LFSR-1:0]  ref_reg, ref_next;
    logic [NB_GOOD-1:0]  good_cnt_reg, good_cnt_next;
    logic [NB_BAD-1:0]   bad_cnt_reg, bad_cnt_next;
    logic                lock_reg, lock_next;
    logic                match_reg, match_next;
    logic                err_inc;

    logic [NB_LFSR-1:0]  bit_eq;
    logic                data_match;
    logic [NB_LFSR-1:0]  nxt_of_data;
    logic [NB_LFSR-1:0]  nxt_of_ref;

    // Per-bit equality of the received word against the reference.
    for (genvar gi = 0; gi < NB_LFSR; gi++) begin : g_bit_eq
        assign bit_eq[gi] = ~(i_data[gi] ^ ref_reg[gi]);
    end
    assign data_match = &bit_eq;

    // Successors of the received word (for seeding) and of the reference.
    assign nxt_of_data = NB_LFSR'(lfsr_next(LFSR_MAX_W'(i_data),
                                            LFSR_MAX_W'(POLY), NB_LFSR));
    assign nxt_of_ref  = NB_LFSR'(lfsr_next(LFSR_MAX_W'(ref_reg),
                                            LFSR_MAX_W'(POLY), NB_LFSR));

    // State, reference, qualification counters and status flags.
    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            state_reg    <= HUNT;
            ref_reg      <= '0;
            good_cnt_reg <= '0;
            bad_cnt_reg  <= '0;
            lock_reg     <= 1'b0;
            match_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            ref_reg      <= ref_next;
            good_cnt_reg <= good_cnt_next;
            bad_cnt_reg  <= bad_cnt_next;
            lock_reg     <= lock_next;
            match_reg    <= match_next;
        end
    end

    // Next-state: resync overrides data; idle cycles hold everything except
    // the match flag, which is only ever a one-cycle pulse.
    always_comb begin
        state_next    = state_reg;
        ref_next      = ref_reg;
        good_cnt_next = good_cnt_reg;
        bad_cnt_next  = bad_cnt_reg;
        lock_next     = lock_reg;
        match_next    = 1'b0;
        err_inc       = 1'b0;

        if (i_resync) begin
            state_next    = HUNT;
            lock_next     = 1'b0;
            good_cnt_next = '0;
            bad_cnt_next  = '0;
        end else if (i_valid) begin
            unique case (state_reg)
                HUNT: begin
                    // Seed word: take it on trust, do not count it.
                    ref_next      = nxt_of_data;
                    good_cnt_next = '0;
                    state_next    = CHECK;
                end
                CHECK: begin
                    if (data_match) begin
                        ref_next      = nxt_of_ref;
                        match_next    = 1'b1;
                        good_cnt_next = good_cnt_reg + NB_GOOD'(1);
                        if (good_cnt_reg == GOOD_LAST) begin
                            lock_next    = 1'b1;
                            bad_cnt_next = '0;
                            state_next   = LOCKED;
                        end
                    end else begin
                        // Re-seed from the offending word without leaving CHECK.
                        ref_next      = nxt_of_data;
                        good_cnt_next = '0;
                    end
                end
                LOCKED: begin
                    // Flywheel: the reference advances regardless of the data.
                    ref_next = nxt_of_ref;
                    if (data_match) begin
                        bad_cnt_next = '0;
                        match_next   = 1'b1;
                    end else begin
                        err_inc      = 1'b1;
                        bad_cnt_next = bad_cnt_reg + NB_BAD'(1);
                        if (bad_cnt_reg == BAD_LAST) begin
                            lock_next     = 1'b0;
                            good_cnt_next = '0;
                            state_next    = HUNT;
                        end
                    end
                end
                default: begin
                    state_next = HUNT;
                end
            endcase
        end
    end

    lfsr_checker_param_err_counter #(
        .NB_CNT (NB_ERR_CNT)
    ) u_err_counter (
        .clk     (clk),
        .i_reset (i_reset),
        .i_clr   (i_clr_err),
        .i_inc   (err_inc),
        .o_cnt   (o_err_cnt)
    );

    assign o_expected = ref_reg;
    assign o_lock     = lock_reg;
    assign o_match    = match_reg;

endmodule

// File: tb/tb_lfsr_checker_param.sv
// Scoreboard bench for lfsr_checker_param with default parameters.
module tb_lfsr_checker_param;

    logic        clk = 1'b0;
    logic        i_reset;
    logic        i_valid;
    logic [7:0]  i_data;
    logic        i_resync;
    logic        i_clr_err;
    logic [7:0]  o_expected;
    logic        o_lock;
    logic        o_match;
    logic [15:0] o_err_cnt;

    typedef struct {
        int          id;
        logic        m;
        logic        l;
        logic [15:0] e;
        logic [7:0]  x;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   txn_id = 0;
    logic txn_active = 1'b0;

    always #5 clk = ~clk;

    lfsr_checker_param dut (
        .clk        (clk),
        .i_reset    (i_reset),
        .i_valid    (i_valid),
        .i_data     (i_data),
        .i_resync   (i_resync),
        .i_clr_err  (i_clr_err),
        .o_expected (o_expected),
        .o_lock     (o_lock),
        .o_match    (o_match),
        .o_err_cnt  (o_err_cnt)
    );

    task automatic chk(input string name, input int id, input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s txn %0d: got %h expected %h", name, id, got, want);
        end
    endtask

    // One cycle of stimulus plus its expected post-edge outputs.
    task automatic drive(input logic v, input logic [7:0] d, input logic rs,
                         input logic ce, input logic em, input logic el,
                         input logic [15:0] ee, input logic [7:0] ex);
        @(negedge clk);
        i_valid    = v;
        i_data     = d;
        i_resync   = rs;
        i_clr_err  = ce;
        txn_active = 1'b1;
        sb_q.push_back('{txn_id, em, el, ee, ex});
        txn_id++;
    endtask

    // Monitor: after each edge that sampled a transaction, pop and compare.
    always @(posedge clk) begin
        if (txn_active) begin
            exp_t e;
            #1;
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_empty at time %0t", $time);
            end else begin
                e = sb_q.pop_front();
                chk("match", e.id, 32'(o_match), 32'(e.m));
                chk("lock", e.id, 32'(o_lock), 32'(e.l));
                chk("err_cnt", e.id, 32'(o_err_cnt), 32'(e.e));
                chk("expected", e.id, 32'(o_expected), 32'(e.x));
                $display("txn %0d: valid=%0b data=%h -> match=%0b lock=%0b err=%0d exp=%h",
                         e.id, i_valid, i_data, o_match, o_lock, o_err_cnt, o_expected);
            end
        end
    end

    initial begin
        i_reset   = 1'b1;
        i_valid   = 1'b0;
        i_data    = 8'h00;
        i_resync  = 1'b0;
        i_clr_err = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_lock", -1, 32'(o_lock), 32'd0);
        chk("rst_match", -1, 32'(o_match), 32'd0);
        chk("rst_err", -1, 32'(o_err_cnt), 32'd0);
        chk("rst_expected", -1, 32'(o_expected), 32'd0);
        i_reset = 1'b0;

        //    v  data   rs  ce  m  l  err  expected
        // Clean sequence: seed + 5 matches locks
        drive(1, 8'h01, 0, 0, 0, 0, 0, 8'h02);
        drive(1, 8'h02, 0, 0, 1, 0, 0, 8'h04);
        drive(1, 8'h04, 0, 0, 1, 0, 0, 8'h08);
        drive(1, 8'h08, 0, 0, 1, 0, 0, 8'h10);
        drive(1, 8'h10, 0, 0, 1, 0, 0, 8'h20);
        drive(1, 8'h20, 0, 0, 1, 1, 0, 8'h40);
        // Zero-insertion wrap
        drive(1, 8'h40, 0, 0, 1, 1, 0, 8'h80);
        drive(1, 8'h80, 0, 0, 1, 1, 0, 8'h00);
        drive(1, 8'h00, 0, 0, 1, 1, 0, 8'h8D);
        drive(1, 8'h8D, 0, 0, 1, 1, 0, 8'h97);
        // Single error while locked, then resume
        drive(1, 8'h55, 0, 0, 0, 1, 1, 8'hA3);
        drive(1, 8'hA3, 0, 0, 1, 1, 1, 8'hCB);
        drive(1, 8'hCB, 0, 0, 1, 1, 1, 8'h1B);
        // Three consecutive errors drop lock (reference keeps advancing)
        drive(1, 8'h00, 0, 0, 0, 1, 2, 8'h36);
        drive(1, 8'h00, 0, 0, 0, 1, 3, 8'h6C);
        drive(1, 8'h00, 0, 0, 0, 0, 4, 8'hD8);
        // Re-lock with six correct words
        drive(1, 8'h01, 0, 0, 0, 0, 4, 8'h02);
        drive(1, 8'h02, 0, 0, 1, 0, 4, 8'h04);
        drive(1, 8'h04, 0, 0, 1, 0, 4, 8'h08);
        drive(1, 8'h08, 0, 0, 1, 0, 4, 8'h10);
        drive(1, 8'h10, 0, 0, 1, 0, 4, 8'h20);
        drive(1, 8'h20, 0, 0, 1, 1, 4, 8'h40);
        // Resync while locked, the valid word is discarded
        drive(1, 8'h40, 1, 0, 0, 0, 4, 8'h40);
        // Mismatch during CHECK re-seeds from FF, no error counted
        drive(1, 8'h01, 0, 0, 0, 0, 4, 8'h02);
        drive(1, 8'h02, 0, 0, 1, 0, 4, 8'h04);
        drive(1, 8'hFF, 0, 0, 0, 0, 4, 8'h73);
        drive(1, 8'h73, 0, 0, 1, 0, 4, 8'hE6);
        drive(1, 8'hE6, 0, 0, 1, 0, 4, 8'h41);
        drive(1, 8'h41, 0, 0, 1, 0, 4, 8'h82);
        drive(1, 8'h82, 0, 0, 1, 0, 4, 8'h89);
        // Valid gaps: nothing moves
        drive(0, 8'h89, 0, 0, 0, 0, 4, 8'h89);
        drive(0, 8'h00, 0, 0, 0, 0, 4, 8'h89);
        drive(1, 8'h89, 0, 0, 1, 1, 4, 8'h9F);
        // Clear coinciding with an error: clear wins
        drive(1, 8'h00, 0, 1, 0, 1, 0, 8'hB3);
        drive(0, 8'h00, 0, 0, 0, 1, 0, 8'hB3);
        drive(1, 8'hB3, 0, 0, 1, 1, 0, 8'hEB);
        drive(1, 8'h00, 0, 0, 0, 1, 1, 8'h5B);
        // Clear alone, then another error, then resync alone
        drive(0, 8'h00, 0, 1, 0, 1, 0, 8'h5B);
        drive(1, 8'h00, 0, 0, 0, 1, 1, 8'hB6);
        drive(0, 8'h00, 1, 0, 0, 0, 1, 8'hB6);

        @(negedge clk);
        txn_active = 1'b0;
        i_valid    = 1'b0;
        i_resync   = 1'b0;
        i_clr_err  = 1'b0;
        for (int w = 0; w < 20 && sb_q.size() != 0; w++) @(negedge clk);
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: %0d pending, expected 0", sb_q.size());
        end

        // Asynchronous reset mid-operation clears outputs immediately
        @(negedge clk);
        #1;
        i_reset = 1'b1;
        #1;
        chk("midrst_err", -2, 32'(o_err_cnt), 32'd0);
        chk("midrst_expected", -2, 32'(o_expected), 32'd0);
        chk("midrst_lock", -2, 32'(o_lock), 32'd0);
        chk("midrst_match", -2, 32'(o_match), 32'd0);
        @(negedge clk);
        i_reset = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
